sampler_mixer: RTL and testbench

SAMPLER_MIXER -- requirements
Module: sampler_mixer

---
 rtl/sampler_mixer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_sampler_mixer.sv | 518 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sampler_mixer.sv
// sampler_mixer: plays up to NUM_VOICES sample streams from a shared storage port.
// Each sample_tick fetches one word per active voice and emits the saturated sum.
module sampler_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 20,
  localparam int ID_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                         clk200,
  input  logic                         reset_n,
  input  logic                         initial_load_finished,
  input  logic [NUM_VOICES-1:0]        trigger,
  input  logic [NUM_VOICES*ADDR_W-1:0] start_a,
  input  logic [NUM_VOICES*LEN_W-1:0]  sample_len,
  input  logic                         sample_tick,
  output logic                         req_valid,
  output logic [ADDR_W-1:0]            req_addr,
  output logic [ID_W-1:0]              req_id,
  input  logic                         req_ready,
  input  logic                         rsp_valid,
  input  logic [ID_W-1:0]              rsp_id,
  input  logic signed [DATA_W-1:0]     rsp_data,
  output logic signed [DATA_W-1:0]     audio_out,
  output logic                         audio_valid,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic                         ready,
  output logic                         overrun
);

  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;

  typedef enum logic {G_INIT = 1'b0, G_READY = 1'b1} gate_e;
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_WAIT = 2'd2,
    M_DONE = 2'd3
  } mix_e;

  gate_e                   gate_q, gate_d;
  mix_e                    mix_q, mix_d;
  logic [NUM_VOICES-1:0]   trig_prev_q, trig_prev_d;
  logic [NUM_VOICES-1:0]   pending_q, pending_d;
  logic [NUM_VOICES-1:0]   active_q, active_d;
  logic [LEN_W-1:0]        pos_q [NUM_VOICES];
  logic [LEN_W-1:0]        pos_d [NUM_VOICES];
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [DATA_W-1:0]       audio_out_q, audio_out_d;
  logic                    audio_valid_q, audio_valid_d;
  logic                    req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
  logic [ID_W-1:0]         req_id_q, req_id_d;
  logic                    overrun_q, overrun_d;

  logic [NUM_VOICES-1:0]   edge_ok_s;
  logic [NUM_VOICES-1:0]   len_nz_s;
  logic [NUM_VOICES-1:0]   last_s;
  logic [NUM_VOICES-1:0]   above_s;
  logic [NUM_VOICES-1:0]   start_s;
  logic [ID_W:0]           pick_s;
  logic [LEN_W-1:0]        len_s [NUM_VOICES];

  // Lowest set bit of a voice mask; MSB of the result flags "found".
  function automatic logic [ID_W:0] first_set(input logic [NUM_VOICES-1:0] m);
    logic [ID_W:0] r;
    r = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = {1'b1, ID_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Storage word address of voice v at its position in p (wraps modulo 2^ADDR_W).
  function automatic logic [ADDR_W-1:0] voice_addr(
    input logic [NUM_VOICES*ADDR_W-1:0] base,
    input logic [LEN_W-1:0]             p [NUM_VOICES],
    input logic [ID_W-1:0]              v
  );
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (ID_W'(i) == v) begin
        a = base[i*ADDR_W +: ADDR_W] + ADDR_W'(p[i]);
      end else begin
        a = a;
      end
    end
    return a;
  endfunction

  // Clamp the wide accumulator into the DATA_W signed range.
  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] a);
    logic [ACC_W-DATA_W:0] top;
    top = a[ACC_W-1:DATA_W-1];
    if ((top == '0) || (top == '1)) begin
      return a[DATA_W-1:0];
    end else if (a[ACC_W-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  // Per-voice decode of lengths, end-of-sample and trigger edges.
  always_comb begin
    edge_ok_s = (gate_q == G_READY) ? (trigger & ~trig_prev_q) : '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      len_s[i]    = sample_len[i*LEN_W +: LEN_W];
      len_nz_s[i] = (len_s[i] != '0);
      last_s[i]   = (pos_q[i] == (len_s[i] - LEN_W'(1)));
      above_s[i]  = (i > int'(req_id_q));
    end
  end

  // Next-state logic for the gate and mixer FSMs and their registered outputs.
  always_comb begin
    gate_d        = gate_q;
    mix_d         = mix_q;
    trig_prev_d   = trigger;
    pending_d     = pending_q | edge_ok_s;
    active_d      = active_q;
    pos_d         = pos_q;
    acc_d         = acc_q;
    audio_out_d   = audio_out_q;
    audio_valid_d = 1'b0;
    req_valid_d   = req_valid_q;
    req_addr_d    = req_addr_q;
    req_id_d      = req_id_q;
    overrun_d     = overrun_q;
    start_s       = '0;
    pick_s        = '0;

    if ((gate_q == G_INIT) && initial_load_finished) begin
      gate_d = G_READY;
    end else begin
      gate_d = gate_q;
    end

    if (sample_tick && (mix_q != M_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (mix_q)
      M_IDLE: begin
        if (sample_tick && (gate_q == G_READY)) begin
          // Zero-length voices are dropped here along with their pending bit.
          start_s   = (pending_q | edge_ok_s) & len_nz_s;
          active_d  = active_q | start_s;
          pending_d = '0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (start_s[i]) begin
              pos_d[i] = '0;
            end else begin
              pos_d[i] = pos_q[i];
            end
          end
          pick_s = first_set(active_d);
          if (pick_s[ID_W]) begin
            mix_d       = M_REQ;
            req_valid_d = 1'b1;
            req_id_d    = pick_s[ID_W-1:0];
            req_addr_d  = voice_addr(start_a, pos_d, pick_s[ID_W-1:0]);
          end else begin
            mix_d = M_DONE;
          end
        end else begin
          mix_d = M_IDLE;
        end
      end
      M_REQ: begin
        if (req_ready) begin
          mix_d       = M_WAIT;
          req_valid_d = 1'b0;
        end else begin
          mix_d = M_REQ;
        end
      end
      M_WAIT: begin
        if (rsp_valid && (rsp_id == req_id_q)) begin
          acc_d = acc_q + {{(ACC_W-DATA_W){rsp_data[DATA_W-1]}}, rsp_data};
          for (int i = 0; i < NUM_VOICES; i++) begin
            if ((ID_W'(i) == req_id_q) && last_s[i]) begin
              active_d[i] = 1'b0;
            end else if (ID_W'(i) == req_id_q) begin
              pos_d[i] = pos_q[i] + LEN_W'(1);
            end else begin
              pos_d[i] = pos_q[i];
            end
          end
          pick_s = first_set(active_q & above_s);
          if (pick_s[ID_W]) begin
            mix_d       = M_REQ;
            req_valid_d = 1'b1;
            req_id_d    = pick_s[ID_W-1:0];
            req_addr_d  = voice_addr(start_a, pos_d, pick_s[ID_W-1:0]);
          end else begin
            mix_d = M_DONE;
          end
        end else begin
          mix_d = M_WAIT;
        end
      end
      M_DONE: begin
        audio_out_d   = saturate(acc_q);
        audio_valid_d = 1'b1;
        acc_d         = '0;
        mix_d         = M_IDLE;
      end
      default: begin
        mix_d       = M_IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk200 or negedge reset_n) begin
    if (!reset_n) begin
      gate_q        <= G_INIT;
      mix_q         <= M_IDLE;
      trig_prev_q   <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        pos_q[i] <= '0;
      end
      acc_q         <= '0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      req_valid_q   <= 1'b0;
      req_addr_q    <= '0;
      req_id_q      <= '0;
      overrun_q     <= 1'b0;
    end else begin
      gate_q        <= gate_d;
      mix_q         <= mix_d;
      trig_prev_q   <= trig_prev_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      pos_q         <= pos_d;
      acc_q         <= acc_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      req_id_q      <= req_id_d;
      overrun_q     <= overrun_d;
    end
  end

  assign req_valid    = req_valid_q;
  assign req_addr     = req_addr_q;
  assign req_id       = req_id_q;
  assign audio_out    = audio_out_q;
  assign audio_valid  = audio_valid_q;
  assign voice_active = active_q;
  assign ready        = (gate_q == G_READY);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sampler_mixer.sv
// Self-checking bench for sampler_mixer: storage responder, audio monitor and a
// frame-level reference model of voices, positions and saturated mixing.
`timescale 1ns/1ps
module tb_sampler_mixer;
  localparam int NV = 4;
  localparam int AW = 27;
  localparam int DW = 16;
  localparam int LW = 20;
  localparam int IW = 2;

  logic                 clk200;
  logic                 reset_n;
  logic                 initial_load_finished;
  logic [NV-1:0]        trigger;
  logic [NV*AW-1:0]     start_a;
  logic [NV*LW-1:0]     sample_len;
  logic                 sample_tick;
  logic                 req_valid;
  logic [AW-1:0]        req_addr;
  logic [IW-1:0]        req_id;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [IW-1:0]        rsp_id;
  logic signed [DW-1:0] rsp_data;
  logic signed [DW-1:0] audio_out;
  logic                 audio_valid;
  logic [NV-1:0]        voice_active;
  logic                 ready;
  logic                 overrun;

  sampler_mixer dut (
    .clk200(clk200), .reset_n(reset_n), .initial_load_finished(initial_load_finished),
    .trigger(trigger), .start_a(start_a), .sample_len(sample_len),
    .sample_tick(sample_tick), .req_valid(req_valid), .req_addr(req_addr),
    .req_id(req_id), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .audio_out(audio_out), .audio_valid(audio_valid),
    .voice_active(voice_active), .ready(ready), .overrun(overrun)
  );

  initial begin
    clk200 = 1'b0;
    forever #2.5 clk200 = ~clk200;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } req_t;

  int n_checks;
  int n_fail;

  // storage model controls
  int                   rsp_delay;
  bit                   junk_en;
  int                   data_mode;
  logic signed [DW-1:0] fixed_data;
  logic [31:0]          salt;
  int                   countdown;
  bit                   junk_pend;
  logic [IW-1:0]        pend_id;
  logic [DW-1:0]        pend_data;

  req_t                 req_log [$];
  req_t                 exp_q [$];
  logic signed [DW-1:0] q_audio [$];

  // reference model state
  bit            m_ready;
  bit            m_active [NV];
  bit            m_pending [NV];
  int            m_pos [NV];
  logic [AW-1:0] cfg_start [NV];
  int            cfg_len [NV];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [31:0] h;
    h = ({5'd0, a} * 32'd40503) ^ salt;
    if (data_mode == 0) return fixed_data;
    else return h[DW-1:0];
  endfunction

  function automatic logic [NV-1:0] m_active_vec();
    logic [NV-1:0] r;
    for (int v = 0; v < NV; v++) r[v] = m_active[v];
    return r;
  endfunction

  function automatic bit m_any_active();
    return m_active_vec() != '0;
  endfunction

  // Storage responder: accepts handshakes, answers after rsp_delay cycles,
  // optionally preceded by a response carrying a foreign voice id.
  initial begin
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_data  = '0;
    countdown = 0;
    junk_pend = 1'b0;
    forever begin
      @(negedge clk200);
      rsp_valid = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          rsp_valid = 1'b1;
          if (junk_pend) begin
            rsp_id    = pend_id + 2'd1;
            rsp_data  = 16'sh7FFF;
            junk_pend = 1'b0;
            countdown = 1;
          end else begin
            rsp_id   = pend_id;
            rsp_data = pend_data;
          end
        end
      end
      if (req_valid && req_ready && reset_n) begin
        req_log.push_back({req_addr, req_id});
        pend_id   = req_id;
        pend_data = word_of(req_addr);
        countdown = rsp_delay;
        junk_pend = junk_en;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk200);
      if (audio_valid) q_audio.push_back(audio_out);
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk200);
      #1;
    end
  endtask

  task automatic apply_cfg();
    for (int v = 0; v < NV; v++) begin
      start_a[v*AW +: AW]    = cfg_start[v];
      sample_len[v*LW +: LW] = LW'(cfg_len[v]);
    end
  endtask

  task automatic trig(input logic [NV-1:0] mask);
    @(posedge clk200); #1 trigger = mask;
    @(posedge clk200); #1 trigger = '0;
    for (int v = 0; v < NV; v++) if (mask[v] && m_ready) m_pending[v] = 1'b1;
  endtask

  task automatic tick_pulse();
    @(posedge clk200); #1 sample_tick = 1'b1;
    @(posedge clk200); #1 sample_tick = 1'b0;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_active[v] = 1'b0; m_pending[v] = 1'b0; m_pos[v] = 0;
    end
  endtask

  // One frame of the specified behaviour: start pending voices, fetch each
  // active voice in ascending order, sum and clamp.
  task automatic model_frame(output logic signed [DW-1:0] exp_audio);
    int sum;
    logic [AW-1:0] a;
    sum = 0;
    exp_q.delete();
    for (int v = 0; v < NV; v++) begin
      if (m_pending[v] && cfg_len[v] != 0) begin
        m_active[v] = 1'b1;
        m_pos[v]    = 0;
      end
      m_pending[v] = 1'b0;
    end
    for (int v = 0; v < NV; v++) begin
      if (m_active[v]) begin
        a = cfg_start[v] + AW'(m_pos[v]);
        exp_q.push_back({a, IW'(v)});
        sum += int'($signed(word_of(a)));
        if (m_pos[v] == cfg_len[v] - 1) m_active[v] = 1'b0;
        else m_pos[v]++;
      end
    end
    if (sum > 32767) exp_audio = 16'sh7FFF;
    else if (sum < -32768) exp_audio = 16'sh8000;
    else exp_audio = DW'(sum);
  endtask

  task automatic do_frame(input string name);
    logic signed [DW-1:0] exp_audio;
    int waited;
    model_frame(exp_audio);
    req_log.delete();
    q_audio.delete();
    tick_pulse();
    waited = 0;
    while (q_audio.size() == 0 && waited < 300) begin
      cycles(1);
      waited++;
    end
    n_checks++;
    if (q_audio.size() != 1) begin
      n_fail++;
      $display("FAIL %s audio_valid_count: got %0d required 1", name, q_audio.size());
    end else begin
      n_checks++;
      if (q_audio[0] !== exp_audio) begin
        n_fail++;
        $display("FAIL %s audio_out: got %h required %h", name, q_audio[0], exp_audio);
      end
    end
    n_checks++;
    if (req_log.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s req_count: got %0d required %0d", name, req_log.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (req_log[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL %s req[%0d] addr/id: got %h/%0d required %h/%0d", name, k,
                   req_log[k].addr, req_log[k].id, exp_q[k].addr, exp_q[k].id);
        end
      end
    end
    n_checks++;
    if (voice_active !== m_active_vec()) begin
      n_fail++;
      $display("FAIL %s voice_active: got %b required %b", name, voice_active, m_active_vec());
    end
  endtask

  task automatic test_reset();
    cycles(3);
    n_checks++;
    if ({req_valid, req_addr, req_id, audio_out, audio_valid, voice_active, ready, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%h/%0d/%h/%b/%b/%b/%b required all zero",
               req_valid, req_addr, req_id, audio_out, audio_valid, voice_active, ready, overrun);
    end
    reset_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_init_gate();
    cfg_start[0] = 27'h100; cfg_len[0] = 3;
    apply_cfg();
    trig(4'b0001);
    for (int i = 0; i < 12; i++) begin
      sample_tick = (i % 4 == 0);
      cycles(1);
      n_checks++;
      if (req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL init_req_valid: got %b required 0 (cycle %0d)", req_valid, i);
      end
    end
    sample_tick = 1'b0;
    cycles(4);
    n_checks++;
    if ({audio_out, voice_active, ready} !== '0 || q_audio.size() != 0) begin
      n_fail++;
      $display("FAIL init_outputs: audio_out=%h voice_active=%b ready=%b pulses=%0d required 0",
               audio_out, voice_active, ready, q_audio.size());
    end
    initial_load_finished = 1'b1;
    cycles(2);
    m_ready = 1'b1;
    n_checks++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_to_ready: got %b required 1", ready);
    end
  endtask

  task automatic test_idle_latency();
    q_audio.delete();
    req_log.delete();
    tick_pulse();
    n_checks++;
    if (audio_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_lat_early: got %b required 0", audio_valid);
    end
    cycles(1);
    n_checks++;
    if (audio_valid !== 1'b1 || audio_out !== 16'sh0000) begin
      n_fail++;
      $display("FAIL idle_lat_valid: got valid=%b out=%h required 1/0000", audio_valid, audio_out);
    end
    cycles(1);
    n_checks++;
    if (audio_valid !== 1'b0 || req_log.size() != 0) begin
      n_fail++;
      $display("FAIL idle_lat_single: got valid=%b reqs=%0d required 0/0", audio_valid, req_log.size());
    end
  endtask

  task automatic test_single_voice();
    data_mode = 0; fixed_data = 16'sh0100;
    cfg_start[0] = 27'h100; cfg_len[0] = 3;
    apply_cfg();
    trig(4'b0001);
    for (int f = 0; f < 3; f++) do_frame($sformatf("single_f%0d", f));
  endtask

  task automatic test_saturation();
    data_mode = 0;
    cfg_start[0] = AW'($urandom); cfg_len[0] = 2;
    cfg_start[1] = AW'($urandom); cfg_len[1] = 2;
    apply_cfg();
    trig(4'b0011);
    fixed_data = 16'sh7000;
    do_frame("sat_pos");
    fixed_data = 16'sh8000;
    do_frame("sat_neg");
  endtask

  task automatic test_order_retrigger();
    data_mode = 1; salt = $urandom;
    cfg_start[0] = AW'($urandom); cfg_len[0] = 6;
    cfg_start[2] = AW'($urandom); cfg_len[2] = 6;
    apply_cfg();
    trig(4'b0101);
    do_frame("order_f0");
    n_checks++;
    if (req_log.size() != 2 || req_log[0].id !== 2'd0 || req_log[1].id !== 2'd2) begin
      n_fail++;
      $display("FAIL order_ids: got %0d entries required ids 0 then 2", req_log.size());
    end
    do_frame("order_f1");
    trig(4'b0001);
    do_frame("retrig_f2");
    n_checks++;
    if (req_log.size() == 0 || req_log[0].addr !== cfg_start[0]) begin
      n_fail++;
      $display("FAIL retrig_addr: got %0d entries required first addr %h", req_log.size(), cfg_start[0]);
    end
  endtask

  task automatic test_random();
    logic [NV-1:0] mask;
    int guard;
    data_mode = 1;
    for (int f = 0; f < 14; f++) begin
      salt = $urandom;
      for (int v = 0; v < NV; v++) begin
        if (!m_active[v] && $urandom_range(0, 1) == 1) begin
          cfg_start[v] = ($urandom_range(0, 3) == 0) ? (27'h7FFFFFF - AW'($urandom_range(0, 2)))
                                                     : AW'($urandom);
          cfg_len[v] = $urandom_range(0, 4);
        end
      end
      apply_cfg();
      mask = NV'($urandom);
      if (mask != '0) trig(mask);
      rsp_delay = $urandom_range(1, 3);
      junk_en   = ($urandom_range(0, 1) == 1);
      do_frame($sformatf("rand_f%0d", f));
    end
    guard = 0;
    while (m_any_active() && guard < 8) begin
      do_frame("rand_drain");
      guard++;
    end
    rsp_delay = 1;
    junk_en   = 1'b0;
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] exp_audio;
    int waited;
    data_mode = 0; fixed_data = 16'sh0042;
    cfg_start[0] = AW'($urandom); cfg_len[0] = 2;
    cfg_start[1] = AW'($urandom); cfg_len[1] = 1;
    apply_cfg();
    trig(4'b0001);
    model_frame(exp_audio);
    req_log.delete();
    q_audio.delete();
    req_ready = 1'b0;
    tick_pulse();
    for (int i = 0; i < 10; i++) begin
      sample_tick = (i % 4 == 1);
      trigger     = (i == 3) ? 4'b0010 : 4'b0000;
      cycles(1);
      n_checks++;
      if (req_valid !== 1'b1 || req_addr !== exp_q[0].addr || req_id !== 2'd0) begin
        n_fail++;
        $display("FAIL bp_stable: got valid=%b addr=%h id=%0d required 1/%h/0 (cycle %0d)",
                 req_valid, req_addr, req_id, exp_q[0].addr, i);
      end
    end
    m_pending[1] = 1'b1;
    sample_tick = 1'b0;
    trigger     = '0;
    req_ready   = 1'b1;
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_overrun: got %b required 1", overrun);
    end
    waited = 0;
    while (q_audio.size() == 0 && waited < 100) begin
      cycles(1);
      waited++;
    end
    cycles(20);
    n_checks++;
    if (q_audio.size() != 1 || req_log.size() != 1) begin
      n_fail++;
      $display("FAIL bp_one_frame: got pulses=%0d reqs=%0d required 1/1", q_audio.size(), req_log.size());
    end else begin
      n_checks++;
      if (q_audio[0] !== exp_audio) begin
        n_fail++;
        $display("FAIL bp_audio: got %h required %h", q_audio[0], exp_audio);
      end
    end
    do_frame("post_stall");
  endtask

  task automatic test_async_reset();
    int waited;
    data_mode = 0; fixed_data = 16'sh1234;
    cfg_start[0] = AW'($urandom); cfg_len[0] = 8;
    apply_cfg();
    trig(4'b0001);
    do_frame("pre_reset");
    rsp_delay = 8;
    req_log.delete();
    q_audio.delete();
    tick_pulse();
    waited = 0;
    while (req_log.size() == 0 && waited < 50) begin
      cycles(1);
      waited++;
    end
    n_checks++;
    if (req_log.size() == 0) begin
      n_fail++;
      $display("FAIL rst_accept: got no request within %0d cycles, required 1", waited);
    end
    cycles(2);
    #0.5 reset_n = 1'b0;
    #0.5;
    n_checks++;
    if ({req_valid, req_addr, req_id, audio_out, audio_valid, voice_active, ready, overrun} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_outputs: got %b/%h/%0d/%h/%b/%b/%b/%b required all zero",
               req_valid, req_addr, req_id, audio_out, audio_valid, voice_active, ready, overrun);
    end
    model_reset();
    m_ready = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(1);
    m_ready = 1'b1;
    waited = 0;
    while (countdown != 0 && waited < 50) begin
      cycles(1);
      waited++;
    end
    cycles(10);
    n_checks++;
    if (q_audio.size() != 0 || voice_active !== '0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_late_rsp: got pulses=%0d active=%b ready=%b required 0/0000/1",
               q_audio.size(), voice_active, ready);
    end
    rsp_delay = 1;
    trig(4'b0001);
    do_frame("post_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n = 1'b0;
    initial_load_finished = 1'b0;
    trigger = '0;
    start_a = '0;
    sample_len = '0;
    sample_tick = 1'b0;
    req_ready = 1'b1;
    rsp_delay = 1;
    junk_en = 1'b0;
    data_mode = 0;
    fixed_data = '0;
    salt = '0;
    m_ready = 1'b0;
    for (int v = 0; v < NV; v++) begin
      cfg_start[v] = '0;
      cfg_len[v] = 0;
    end
    model_reset();

    test_reset();
    test_init_gate();
    test_idle_latency();
    test_single_voice();
    test_saturation();
    test_order_retrigger();
    test_random();
    test_backpressure();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
